// File: rtl/sensor_top.sv
// sensor_top: erase/expose/ramp-ADC convert/read pixel array; in output_clk, reset (sync low), scene_in; out data_out, data_valid, new_row, frame_done
module sensor_top #(
  parameter int PIXEL_ARRAY_WIDTH  = 4,
  parameter int PIXEL_ARRAY_HEIGHT = 4,
  parameter int PIXEL_BITS         = 8,
  parameter int OUTPUT_BUS_WIDTH   = 4,
  parameter int EXPOSE_CYCLES      = 8
) (
  input  logic                                                     output_clk,
  input  logic                                                     reset,
  input  logic [PIXEL_ARRAY_HEIGHT*PIXEL_ARRAY_WIDTH*PIXEL_BITS-1:0] scene_in,
  output logic [OUTPUT_BUS_WIDTH*PIXEL_BITS-1:0]                   data_out,
  output logic                                                     data_valid,
  output logic                                                     new_row,
  output logic                                                     frame_done
);
  localparam int N = PIXEL_ARRAY_HEIGHT * PIXEL_ARRAY_WIDTH;
  localparam int BEATS = N / OUTPUT_BUS_WIDTH;
  localparam int BPR = PIXEL_ARRAY_WIDTH / OUTPUT_BUS_WIDTH;
  localparam int CMAX = EXPOSE_CYCLES > BEATS ? EXPOSE_CYCLES : BEATS;
  localparam int CW = $clog2(CMAX + 1);
  localparam int IW = $clog2(N);
  typedef enum logic [1:0] {ERASE, EXPOSE, CONVERT, READ} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [PIXEL_BITS-1:0] ramp;
  logic [PIXEL_BITS-1:0] snap [N];
  logic [PIXEL_BITS-1:0] pix [N];
  logic [OUTPUT_BUS_WIDTH*PIXEL_BITS-1:0] beat;
  logic exp_last, conv_last, read_last;
  assign exp_last = state == EXPOSE && cnt == CW'(EXPOSE_CYCLES - 1);
  assign conv_last = state == CONVERT && &ramp;
  assign read_last = state == READ && cnt == CW'(BEATS - 1);
  always_ff @(posedge output_clk)
    if (!reset) state <= ERASE;
    else state <= state_nx;
  always_comb begin
    state_nx = state == ERASE ? EXPOSE :
               state == EXPOSE ? (exp_last ? CONVERT : EXPOSE) :
               state == CONVERT ? (conv_last ? READ : CONVERT) :
               (read_last ? ERASE : READ);
  end
  always_ff @(posedge output_clk)
    if (!reset || state == ERASE) begin
      cnt <= '0;
      ramp <= '0;
    end else begin
      cnt <= (exp_last || read_last) ? '0 : (state == EXPOSE || state == READ) ? cnt + 1'b1 : cnt;
      ramp <= state == CONVERT ? ramp + 1'b1 : '0;
    end
  // The ramp passes each snapshot value exactly once, so the store is written once and then held.
  always_ff @(posedge output_clk)
    for (int i = 0; i < N; i++)
      if (!reset) begin
        snap[i] <= '0;
        pix[i] <= '0;
      end else if (state == ERASE) pix[i] <= '0;
      else if (exp_last) snap[i] <= scene_in[i*PIXEL_BITS +: PIXEL_BITS];
      else if (state == CONVERT && ramp == snap[i]) pix[i] <= ramp;
  always_comb begin
    beat = '0;
    for (int i = 0; i < OUTPUT_BUS_WIDTH; i++)
      beat[i*PIXEL_BITS +: PIXEL_BITS] = pix[IW'(int'(cnt) * OUTPUT_BUS_WIDTH + i)];
  end
  always_ff @(posedge output_clk)
    if (!reset) begin
      data_out <= '0;
      data_valid <= 1'b0;
      new_row <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      data_out <= state == READ ? beat : '0;
      data_valid <= state == READ;
      new_row <= state == READ && (cnt % CW'(BPR)) == '0;
      frame_done <= read_last;
    end
endmodule

// File: tb/tb_sensor_top.sv
// tb_sensor_top: scoreboard bench for a default sensor_top and an 8-wide variant sharing clock and reset
module tb_sensor_top;
  typedef struct {
    int t;
    logic [31:0] d;
    logic nr;
    logic fd;
  } exp_t;
  logic output_clk = 1'b0;
  logic reset = 1'b0;
  logic [127:0] scene1 = '0;
  logic [255:0] scene2 = '0;
  logic [31:0] d1, d2;
  logic dv1, dv2, nr1, nr2, fd1, fd2;
  int e = -1;
  int errors = 0;
  int checks = 0;
  exp_t q [2][$];
  localparam int B0 = 3;
  localparam int B1 = B0 + 1009;
  sensor_top dut1 (
    .output_clk(output_clk), .reset(reset), .scene_in(scene1),
    .data_out(d1), .data_valid(dv1), .new_row(nr1), .frame_done(fd1)
  );
  sensor_top #(.PIXEL_ARRAY_WIDTH(8)) dut2 (
    .output_clk(output_clk), .reset(reset), .scene_in(scene2),
    .data_out(d2), .data_valid(dv2), .new_row(nr2), .frame_done(fd2)
  );
  always #5 output_clk = ~output_clk;
  always @(posedge output_clk) e <= e + 1;
  task automatic push_frame(input int id, input int start, input logic [255:0] exp_beats,
                            input int nb, input int bpr);
    exp_t x;
    for (int k = 0; k < nb; k++) begin
      x.t = start + k;
      x.d = exp_beats[k*32 +: 32];
      x.nr = (k % bpr) == 0;
      x.fd = k == nb - 1;
      q[id].push_back(x);
    end
  endtask
  task automatic check_out(input int id, input logic dv, input logic [31:0] d,
                           input logic nr, input logic fd);
    exp_t x;
    checks++;
    if (dv === 1'b1) begin
      if (q[id].size() == 0) begin
        errors++;
        $display("FAIL dut%0d unexpected_beat at edge %0d: got d=%h nr=%b fd=%b, want no beat", id + 1, e, d, nr, fd);
      end else begin
        x = q[id].pop_front();
        if (x.t != e || d !== x.d || nr !== x.nr || fd !== x.fd) begin
          errors++;
          $display("FAIL dut%0d beat: got edge=%0d d=%h nr=%b fd=%b, want edge=%0d d=%h nr=%b fd=%b",
                   id + 1, e, d, nr, fd, x.t, x.d, x.nr, x.fd);
        end
      end
    end else if (dv !== 1'b0 || d !== '0 || nr !== 1'b0 || fd !== 1'b0) begin
      errors++;
      $display("FAIL dut%0d idle_outputs at edge %0d: got dv=%b d=%h nr=%b fd=%b, want all zero", id + 1, e, dv, d, nr, fd);
    end
  endtask
  always @(negedge output_clk)
    if (e >= 0) begin
      check_out(0, dv1, d1, nr1, fd1);
      check_out(1, dv2, d2, nr2, fd2);
    end
  task automatic wait_e(input int n);
    while (e < n) @(negedge output_clk);
  endtask
  initial begin
    push_frame(0, B0 + 265, {128'h0, {16{8'h10}}}, 4, 1);
    push_frame(0, B0 + 534, {128'h0, 128'hFF323130_23222120_13121110_03020100}, 4, 1);
    push_frame(0, B0 + 803, {128'h0, 128'h8f8e8d8c_8b8a8988_87868584_83828180}, 4, 1);
    push_frame(0, B1 + 265, {128'h0, 128'h8f8e8d8c_8b8a8988_87868584_83828180}, 4, 1);
    for (int f = 0; f < 3; f++)
      push_frame(1, B0 + 265 + 273 * f,
                 256'h1f1e1d1c_1b1a1918_17161514_13121110_0f0e0d0c_0b0a0908_07060504_03020100, 8, 2);
    push_frame(1, B1 + 265,
               256'h1f1e1d1c_1b1a1918_17161514_13121110_0f0e0d0c_0b0a0908_07060504_03020100, 8, 2);
    for (int p = 0; p < 32; p++) scene2[p*8 +: 8] = 8'(p);
    wait_e(B0 - 1);
    reset = 1'b1;
    scene1 = {16{8'h10}};
    wait_e(B0 + 100);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) scene1[(r*4+c)*8 +: 8] = 8'(16 * r + c);
    scene1[15*8 +: 8] = 8'hFF;
    wait_e(B0 + 269 + 100);
    for (int p = 0; p < 16; p++) scene1[p*8 +: 8] = 8'(8'h80 + p);
    wait_e(B0 + 1006);
    reset = 1'b0;
    wait_e(B0 + 1008);
    reset = 1'b1;
    wait_e(B1 + 280);
    for (int id = 0; id < 2; id++) begin
      checks++;
      if (q[id].size() != 0) begin
        errors++;
        $display("FAIL dut%0d missing_beats: got %0d left in queue, want 0", id + 1, q[id].size());
      end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sensor_top.md
SENSOR_TOP -- requirements
Module: sensor_top

Interface
REQ-001 Parameter PIXEL_ARRAY_WIDTH, default 4: pixels per row; SHALL be a multiple of OUTPUT_BUS_WIDTH.
REQ-002 Parameter PIXEL_ARRAY_HEIGHT, default 4: number of rows.
REQ-003 Parameter PIXEL_BITS, default 8: bits per pixel value.
REQ-004 Parameter OUTPUT_BUS_WIDTH, default 4: pixels per output beat.
REQ-005 Parameter EXPOSE_CYCLES, default 8: exposure length in cycles, minimum 1.
REQ-006 output_clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-007 reset  input  1  synchronous, active-low; clock output_clk.
REQ-008 scene_in  input  HEIGHT*WIDTH*PIXEL_BITS  light level per pixel; pixel (r,c) at slice index r*WIDTH+c, LSB-first.
REQ-009 data_out  output  OUTPUT_BUS_WIDTH*PIXEL_BITS  beat of pixel values; lane i at slice i.
REQ-010 data_valid  output  1  high on every beat carrying pixel data.
REQ-011 new_row  output  1  high on the first beat of each row.
REQ-012 frame_done  output  1  one-cycle pulse on the last beat of a frame.

Function
REQ-013 Block SHALL run a 4-state FSM: ERASE -> EXPOSE -> CONVERT -> READ -> ERASE, running frames continuously.
REQ-014 ERASE SHALL last exactly 1 cycle and clear all pixel stores and the ADC ramp counter to 0.
REQ-015 EXPOSE SHALL last EXPOSE_CYCLES cycles; on its last cycle the block SHALL latch scene_in into an internal snapshot; scene_in changes at any other time SHALL NOT affect the frame.
REQ-016 CONVERT SHALL last 2^PIXEL_BITS cycles; a PIXEL_BITS ramp counter SHALL count 0 to 2^PIXEL_BITS-1, one step per cycle.
REQ-017 Each pixel store SHALL capture the ramp value in the first CONVERT cycle where ramp equals its snapshot value and SHALL hold it thereafter; the resulting stored value equals the snapshot value (0 captured on the first CONVERT cycle; all-ones on the last).
REQ-018 READ SHALL last HEIGHT*WIDTH/OUTPUT_BUS_WIDTH cycles, row 0 first, each row left to right, one beat per cycle; beat k of row r carries pixels (r, k*BUS .. k*BUS+BUS-1) on lanes 0..BUS-1.
REQ-019 data_valid SHALL be high in every READ cycle and low in all other states.
REQ-020 new_row SHALL be high in the READ cycle of beat 0 of each row and low otherwise.
REQ-021 frame_done SHALL be high only in the final READ cycle.
REQ-022 data_out SHALL be all-zero whenever data_valid is low.
REQ-023 Outputs SHALL be registered; with defaults, one frame is 1+8+256+4 = 269 cycles.
REQ-024 All counters SHALL wrap to 0 on state exit; no counter may overflow within a state.

Reset
REQ-025 While reset is low at a rising edge: FSM -> ERASE, all counters, pixel stores and snapshot -> 0, data_out = 0, data_valid = new_row = frame_done = 0.
REQ-026 The first rising edge with reset high SHALL execute the ERASE cycle (cycle 0); a reset asserted mid-frame SHALL abort the frame without emitting further valid beats.

Verification
REQ-027 Defaults, scene all 0x10, reset released: cycles 0 ERASE, 1-8 EXPOSE, 9-264 CONVERT; cycles 265-268 data_valid=1, each lane 0x10, new_row=1 every beat, frame_done=1 at cycle 268; cycle 269 ERASE.
REQ-028 Scene pixel (r,c) = 16*r + c: beat of row 2 SHALL show lanes 0x20,0x21,0x22,0x23.
REQ-029 Boundary values: pixel (0,0)=0x00, pixel (3,3)=0xFF -> read back exactly 0x00 and 0xFF.
REQ-030 Change scene_in during CONVERT (cycle 100) -> frame output reflects the value present at cycle 8; next frame reflects the new value.
REQ-031 Assert reset at cycle 200 for 2 cycles -> all outputs 0 while low; after release, first valid beat 265 cycles after the first high edge, with no valid beat in between.
REQ-032 Non-default WIDTH=8, BUS=4 -> 2 beats per row, new_row on alternate beats, frame_done on beat 8 of READ.
